// File: rtl/rca_pkg.sv
// Shared constants and types for the 4-bit ripple-carry adder benchmark block.
package rca_pkg;

  localparam int RCA_W = 4;

  typedef logic [RCA_W-1:0] operand_t;
  typedef logic [RCA_W:0]   result_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the ripple chain in rca_4b is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_4b.sv
// 4-bit ripple-carry adder: combinational {carry-out, sum} plus a registered copy.
module rca_4b
  import rca_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RCA_W-1:0] in0,
  input  logic [RCA_W-1:0] in1,
  input  logic             in2,
  output logic [RCA_W:0]   out0,
  output logic [RCA_W:0]   out0_q
);

  logic [RCA_W:0]   carry;
  logic [RCA_W-1:0] sum;

  assign carry[0] = in2;

  // The gate-level ripple is the point of the benchmark, so no behavioural '+' here.
  for (genvar i = 0; i < RCA_W; i++) begin : g_bit
    full_adder u_fa (
      .a    (in0[i]),
      .b    (in1[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign out0 = {carry[RCA_W], sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_q <= '0;
    end else begin
      out0_q <= out0;
    end
  end

endmodule

// File: tb/tb_rca_4b.sv
// Scoreboard bench for rca_4b: integer-sum reference model, queued expectations, decoupled monitors.
module tb_rca_4b;

  logic       clk;
  logic       rst_n;
  logic [3:0] in0;
  logic [3:0] in1;
  logic       in2;
  logic [4:0] out0;
  logic [4:0] out0_q;

  logic       strobe;
  logic [4:0] combQ[$];
  logic [4:0] regQ[$];
  int         nCompared;
  int         nMismatched;

  rca_4b dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .out0   (out0),
    .out0_q (out0_q)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic logic [4:0] refSum(input int a, input int b, input int c);
    int total;
    total = a + b + c;
    return total[4:0];
  endfunction

  task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Inputs change on the falling edge; the combinational result is sampled 10 ns later.
  task automatic applyStimulus(input int a, input int b, input int c);
    @(negedge clk);
    in0 = 4'(a);
    in1 = 4'(b);
    in2 = 1'(c);
    combQ.push_back(refSum(a, b, c));
    #10;
    strobe = 1'b1;
    #1;
    strobe = 1'b0;
  endtask

  always @(posedge strobe) begin
    if (combQ.size() > 0) begin
      checkOutput("out0", out0, combQ.pop_front());
    end
  end

  // Reference for the register: what the sum is at each rising edge, or zero while in reset.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      regQ.push_back(refSum(int'(in0), int'(in1), int'(in2)));
    end else begin
      regQ.push_back(5'd0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (regQ.size() > 0) begin
      checkOutput("out0_q", out0_q, regQ.pop_front());
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    strobe      = 1'b0;
    rst_n       = 1'b1;
    in0         = 4'd9;
    in1         = 4'd3;
    in2         = 1'b1;

    #5;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async_clear", out0_q, 5'd0);
    repeat (2) applyStimulus(9, 3, 1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(9, 3, 1);

    applyStimulus(0, 0, 0);
    applyStimulus(15, 15, 1);
    applyStimulus(15, 0, 1);
    applyStimulus(15, 0, 0);
    applyStimulus(7, 8, 0);
    applyStimulus(5, 10, 1);
    applyStimulus(0, 15, 1);

    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          applyStimulus(a, b, c);
          $display("[TB] %0d", out0);
        end
      end
    end

    for (int n = 0; n < 48; n++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
      if (n == 20 || n == 35) begin
        rst_n = 1'b0;
        #1;
        checkOutput("reset_midstream", out0_q, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drain", 5'(combQ.size()), 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
